// File: rtl/counter_cfg_sequencer.sv
// Timebase counter sequencer: stages configuration from the register block, commits it to the
// live counter configuration only at wrap boundaries, and drives the counter's enable/clear.
module counter_cfg_sequencer #(
   parameter int CW = 16,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_period,
   input  logic [PW-1:0] cfg_prescale,
   input  logic          cfg_up,
   input  logic          start,
   input  logic          stop,
   input  logic          oneshot,
   input  logic [CW-1:0] count_val,
   output logic [CW-1:0] period,
   output logic [PW-1:0] prescale,
   output logic          upnotdown,
   output logic          en,
   output logic          count_reset,
   output logic          update_evt,
   output logic          done,
   output logic          running
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] period_q, period_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic          upnotdown_q, upnotdown_d;
   logic [CW-1:0] sh_period_q, sh_period_d;
   logic [PW-1:0] sh_prescale_q, sh_prescale_d;
   logic          sh_up_q, sh_up_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] prev_q, prev_d;
   logic          cfg_ready_q, cfg_ready_d;
   logic          en_q, en_d;
   logic          count_reset_q, count_reset_d;
   logic          update_evt_q, update_evt_d;
   logic          done_q, done_d;
   logic          running_q, running_d;

   logic [CW-1:0] wrap_val_s;
   logic          boundary_s;
   logic          commit_s;

   // A boundary is the counter arriving at its wrap value; a zero period wraps every cycle.
   always_comb begin
      wrap_val_s = upnotdown_q ? {CW{1'b0}} : period_q;
      if (state_q != ST_RUN) begin
         boundary_s = 1'b0;
      end else if (period_q == {CW{1'b0}}) begin
         boundary_s = 1'b1;
      end else begin
         boundary_s = (count_val != prev_q) && (count_val == wrap_val_s);
      end
   end

   // Next-state, staging/commit and registered-output computation.
   always_comb begin
      state_d       = state_q;
      period_d      = period_q;
      prescale_d    = prescale_q;
      upnotdown_d   = upnotdown_q;
      sh_period_d   = sh_period_q;
      sh_prescale_d = sh_prescale_q;
      sh_up_d       = sh_up_q;
      pend_d        = pend_q;
      prev_d        = count_val;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: commit_s = pend_q;
         ST_ARM:  commit_s = pend_q;
         ST_RUN:  commit_s = pend_q && boundary_s;
         default: commit_s = 1'b0;
      endcase

      // A pending shadow blocks new captures, so commit and capture never coincide.
      if (commit_s) begin
         period_d    = sh_period_q;
         prescale_d  = sh_prescale_q;
         upnotdown_d = sh_up_q;
         pend_d      = 1'b0;
      end else if (cfg_valid && !pend_q) begin
         sh_period_d   = cfg_period;
         sh_prescale_d = cfg_prescale;
         sh_up_d       = cfg_up;
         pend_d        = 1'b1;
      end else begin
         pend_d = pend_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_ARM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (oneshot && boundary_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered images of the state being entered.
      cfg_ready_d   = !pend_d;
      update_evt_d  = commit_s;
      en_d          = (state_d == ST_RUN);
      running_d     = (state_d == ST_RUN);
      count_reset_d = (state_d == ST_ARM);
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         period_q      <= {CW{1'b0}};
         prescale_q    <= {PW{1'b0}};
         upnotdown_q   <= 1'b1;
         sh_period_q   <= {CW{1'b0}};
         sh_prescale_q <= {PW{1'b0}};
         sh_up_q       <= 1'b0;
         pend_q        <= 1'b0;
         prev_q        <= {CW{1'b0}};
         cfg_ready_q   <= 1'b1;
         en_q          <= 1'b0;
         count_reset_q <= 1'b0;
         update_evt_q  <= 1'b0;
         done_q        <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         period_q      <= period_d;
         prescale_q    <= prescale_d;
         upnotdown_q   <= upnotdown_d;
         sh_period_q   <= sh_period_d;
         sh_prescale_q <= sh_prescale_d;
         sh_up_q       <= sh_up_d;
         pend_q        <= pend_d;
         prev_q        <= prev_d;
         cfg_ready_q   <= cfg_ready_d;
         en_q          <= en_d;
         count_reset_q <= count_reset_d;
         update_evt_q  <= update_evt_d;
         done_q        <= done_d;
         running_q     <= running_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign period      = period_q;
   assign prescale    = prescale_q;
   assign upnotdown   = upnotdown_q;
   assign en          = en_q;
   assign count_reset = count_reset_q;
   assign update_evt  = update_evt_q;
   assign done        = done_q;
   assign running     = running_q;

endmodule

// File: tb/tb_counter_cfg_sequencer.sv
// Bench for counter_cfg_sequencer: a modelled PWM counter closes the count_val loop, and a
// transaction-level reference model predicts every output on every cycle.
module tb_counter_cfg_sequencer;
   localparam int CW = 16;
   localparam int PW = 8;
   localparam int M_IDLE = 0;
   localparam int M_ARM  = 1;
   localparam int M_RUN  = 2;

   logic          clk;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_period;
   logic [PW-1:0] cfg_prescale;
   logic          cfg_up;
   logic          start;
   logic          stop;
   logic          oneshot;
   logic [CW-1:0] count_val;
   logic [CW-1:0] period;
   logic [PW-1:0] prescale;
   logic          upnotdown;
   logic          en;
   logic          count_reset;
   logic          update_evt;
   logic          done;
   logic          running;

   int errors = 0;
   int checks = 0;
   int p_cnt  = 0;

   // reference model state
   int            m_state;
   logic [CW-1:0] m_period, m_sh_period, m_prev;
   logic [PW-1:0] m_prescale, m_sh_prescale;
   logic          m_up, m_sh_up, m_pend, m_evt, m_done;

   counter_cfg_sequencer #(.CW(CW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_up(cfg_up),
      .start(start), .stop(stop), .oneshot(oneshot), .count_val(count_val),
      .period(period), .prescale(prescale), .upnotdown(upnotdown), .en(en),
      .count_reset(count_reset), .update_evt(update_evt), .done(done), .running(running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] cnt_step(logic [CW-1:0] c, logic [CW-1:0] p, logic up);
      if (up) return (c >= p) ? 16'd0 : c + 16'd1;
      return (c == 16'd0 || c > p) ? p : c - 16'd1;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_period = '0; m_prescale = '0; m_up = 1'b1;
      m_sh_period = '0; m_sh_prescale = '0; m_sh_up = 1'b0;
      m_pend = 1'b0; m_prev = '0; m_evt = 1'b0; m_done = 1'b0;
   endtask

   // One clock of the behavioural rules, evaluated on the values present before the edge.
   task automatic model_step();
      bit bnd, commit;
      int nst;
      bnd = (m_state == M_RUN) &&
            (m_period == 0 || (count_val != m_prev && count_val == (m_up ? 16'd0 : m_period)));
      commit = m_pend && (m_state != M_RUN || bnd);
      m_evt = commit;
      m_done = 1'b0;
      if (commit) begin
         m_period = m_sh_period; m_prescale = m_sh_prescale; m_up = m_sh_up; m_pend = 1'b0;
      end else if (cfg_valid && !m_pend) begin
         m_sh_period = cfg_period; m_sh_prescale = cfg_prescale; m_sh_up = cfg_up; m_pend = 1'b1;
      end
      nst = m_state;
      if (stop) nst = M_IDLE;
      else if (m_state == M_IDLE && start) nst = M_ARM;
      else if (m_state == M_ARM) nst = M_RUN;
      else if (m_state == M_RUN && oneshot && bnd) begin
         nst = M_IDLE; m_done = 1'b1;
      end
      m_prev = count_val;
      m_state = nst;
   endtask

   // Advance one clock: counter environment, model, then a full output comparison.
   task automatic tick();
      logic [CW-1:0] c_next;
      int p_next;
      logic [30:0] exp_v, act_v;
      c_next = count_val; p_next = p_cnt;
      if (!rst_n || count_reset) begin
         c_next = '0; p_next = 0;
      end else if (en) begin
         if (p_cnt >= (1 << prescale) - 1) begin
            p_next = 0; c_next = cnt_step(count_val, period, upnotdown);
         end else begin
            p_next = p_cnt + 1;
         end
      end
      if (!rst_n) model_reset(); else model_step();
      @(posedge clk);
      #1;
      count_val = c_next; p_cnt = p_next;
      exp_v = {m_period, m_prescale, m_up, m_state == M_RUN, m_state == M_ARM, !m_pend,
               m_evt, m_done, m_state == M_RUN};
      act_v = {period, prescale, upnotdown, en, count_reset, cfg_ready, update_evt, done, running};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
   endtask

   task automatic do_cfg(input logic [CW-1:0] p, input logic [PW-1:0] ps, input logic up);
      cfg_valid = 1'b1; cfg_period = p; cfg_prescale = ps; cfg_up = up;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({period, prescale, upnotdown, en, count_reset, cfg_ready, update_evt, done, running} !==
          {16'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values actual=%h%h%b%b%b%b%b%b%b", period, prescale, upnotdown, en,
                  count_reset, cfg_ready, update_evt, done, running);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_cfg_idle();
      do_cfg(16'd9, 8'd0, 1'b1);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++; $display("FAIL stage_ready actual=%b expected=0", cfg_ready);
      end
      tick();
      checks++;
      if (period !== 16'd9 || update_evt !== 1'b1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_commit period=%0d evt=%b ready=%b expected 9/1/1", period, update_evt, cfg_ready);
      end
      tick();
      checks++;
      if (update_evt !== 1'b0) begin
         errors++; $display("FAIL evt_pulse actual=%b expected=0", update_evt);
      end
   endtask

   task automatic test_start_count();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (count_reset !== 1'b1 || en !== 1'b0) begin
         errors++; $display("FAIL arm cr=%b en=%b expected 1/0", count_reset, en);
      end
      tick();
      checks++;
      if (count_reset !== 1'b0 || en !== 1'b1) begin
         errors++; $display("FAIL run_entry cr=%b en=%b expected 0/1", count_reset, en);
      end
      for (int i = 0; i <= 10; i++) begin
         checks++;
         if (count_val !== 16'(i % 10) || running !== 1'b1) begin
            errors++;
            $display("FAIL count_seq step=%0d count=%0d running=%b expected %0d/1", i, count_val, running, i % 10);
         end
         tick();
      end
   endtask

   task automatic test_cfg_run();
      logic [CW-1:0] held;
      int g;
      g = 0;
      while (count_val != 16'd3 && g < 30) begin tick(); g++; end
      checks++;
      if (count_val !== 16'd3) begin
         errors++; $display("FAIL reach_3 actual=%0d expected=3", count_val);
      end
      do_cfg(16'd4, 8'd0, 1'b1);
      g = 0;
      while (count_val != 16'd0 && g < 30) begin
         checks++;
         if (period !== 16'd9 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL hold_period period=%0d ready=%b expected 9/0", period, cfg_ready);
         end
         tick(); g++;
      end
      checks++;
      if (count_val !== 16'd0 || period !== 16'd9) begin
         errors++; $display("FAIL at_wrap count=%0d period=%0d expected 0/9", count_val, period);
      end
      tick();
      checks++;
      if (period !== 16'd4 || update_evt !== 1'b1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_commit period=%0d evt=%b ready=%b expected 4/1/1", period, update_evt, cfg_ready);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (en !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL stop en=%b running=%b expected 0/0", en, running);
      end
      held = count_val;
      tick(); tick();
      checks++;
      if (count_val !== held) begin
         errors++; $display("FAIL stop_hold actual=%0d expected=%0d", count_val, held);
      end
   endtask

   task automatic test_oneshot();
      logic [CW-1:0] held;
      int n;
      bit seen;
      apply_reset();
      do_cfg(16'd3, 8'd0, 1'b1);
      tick();
      oneshot = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         tick(); n++;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || n != 6 || en !== 1'b0) begin
         errors++; $display("FAIL oneshot_done seen=%b cycles=%0d en=%b expected 1/6/0", seen, n, en);
      end
      tick();
      held = count_val;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse actual=%b expected=0", done);
      end
      tick(); tick();
      checks++;
      if (count_val !== held) begin
         errors++; $display("FAIL oneshot_hold actual=%0d expected=%0d", count_val, held);
      end
      oneshot = 1'b0;
   endtask

   task automatic test_start_stop_same();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
      checks++;
      if (en !== 1'b0 || count_reset !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL start_stop en=%b cr=%b running=%b expected 0/0/0", en, count_reset, running);
      end
   endtask

   task automatic test_reset_midrun();
      int g;
      do_cfg(16'd9, 8'd0, 1'b1);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      g = 0;
      while ((count_val != 16'd5 || running !== 1'b1) && g < 40) begin tick(); g++; end
      checks++;
      if (count_val !== 16'd5 || running !== 1'b1) begin
         errors++; $display("FAIL reach_5 count=%0d running=%b expected 5/1", count_val, running);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (en !== 1'b0 || period !== 16'd0 || cfg_ready !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL async_reset en=%b period=%0d ready=%b running=%b expected 0/0/1/0", en, period, cfg_ready, running);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cfg_valid    = ($urandom_range(0, 2) == 0);
         cfg_period   = 16'($urandom_range(0, 7));
         cfg_prescale = 8'($urandom_range(0, 2));
         cfg_up       = 1'($urandom_range(0, 1));
         start        = ($urandom_range(0, 5) == 0);
         stop         = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 15) == 0) oneshot = 1'($urandom_range(0, 1));
         rst_n        = ($urandom_range(0, 149) != 0);
         tick();
      end
      cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_up = 1'b1;
      start = 1'b0; stop = 1'b0; oneshot = 1'b0; count_val = '0;
      model_reset();
      test_reset();
      test_cfg_idle();
      test_start_count();
      test_cfg_run();
      test_oneshot();
      test_start_stop_same();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
